// File: rtl/scoreboard_stall_unit_if.sv
// scoreboard_stall_unit_if: ID-stage request, long-op completion and scoreboard status signals
interface scoreboard_stall_unit_if;
  logic        id_valid_i;
  logic [4:0]  id_rs1_i;
  logic [4:0]  id_rs2_i;
  logic        id_use_rs1_i;
  logic        id_use_rs2_i;
  logic [4:0]  id_rd_i;
  logic        id_regwrite_i;
  logic [1:0]  id_class_i;
  logic        issue_i;
  logic        long_done_i;
  logic [4:0]  long_rd_i;
  logic        stall_o;
  logic [31:0] pending_o;
  logic [2:0]  long_cnt_o;
  logic        err_o;
  modport master (
    output id_valid_i, id_rs1_i, id_rs2_i, id_use_rs1_i, id_use_rs2_i, id_rd_i, id_regwrite_i,
           id_class_i, issue_i, long_done_i, long_rd_i,
    input  stall_o, pending_o, long_cnt_o, err_o
  );
  modport slave (
    input  id_valid_i, id_rs1_i, id_rs2_i, id_use_rs1_i, id_use_rs2_i, id_rd_i, id_regwrite_i,
           id_class_i, issue_i, long_done_i, long_rd_i,
    output stall_o, pending_o, long_cnt_o, err_o
  );
endinterface

// File: rtl/scoreboard_stall_unit.sv
// scoreboard_stall_unit: tracks unforwardable load and MUL/DIV writes and stalls ID on hazards
module scoreboard_stall_unit #(
  parameter int LOAD_LAT = 1,
  parameter int MAX_LONG = 2
) (
  input logic clk_i,
  input logic rst_n_i,
  scoreboard_stall_unit_if.slave sb
);
  localparam logic [1:0] LOAD = 2'b01, LONG = 2'b10;
  logic [31:0] pend_load, pend_long, pending;
  logic [1:0]  load_cnt [32];
  logic [2:0]  long_cnt;
  logic [3:0]  cnt_sum;
  logic        err, wr, is_long, full, raw, waw;
  assign pending = pend_load | pend_long;
  assign wr = sb.issue_i & sb.id_regwrite_i & (sb.id_rd_i != 5'd0);
  assign is_long = sb.id_class_i == LONG;
  assign full = long_cnt == 3'(MAX_LONG);
  assign raw = (sb.id_use_rs1_i & (sb.id_rs1_i != 5'd0) & pending[sb.id_rs1_i]) |
               (sb.id_use_rs2_i & (sb.id_rs2_i != 5'd0) & pending[sb.id_rs2_i]);
  assign waw = sb.id_regwrite_i & (sb.id_rd_i != 5'd0) & pend_long[sb.id_rd_i];
  assign sb.stall_o = sb.id_valid_i & (raw | waw | (is_long & full));
  assign sb.pending_o = pending;
  assign sb.long_cnt_o = long_cnt;
  assign sb.err_o = err;
  // decrement only when nonzero, so the sum never underflows; overflow saturates below
  assign cnt_sum = {1'b0, long_cnt} + {3'b0, sb.issue_i & is_long} - {3'b0, sb.long_done_i & (long_cnt != 3'd0)};
  always_ff @(posedge clk_i or negedge rst_n_i)
    if (!rst_n_i) begin
      pend_load <= '0;
      pend_long <= '0;
      long_cnt <= '0;
      err <= 1'b0;
      for (int r = 0; r < 32; r++) load_cnt[r] <= '0;
    end else begin
      for (int r = 1; r < 32; r++) begin
        if (wr && sb.id_class_i == LOAD && sb.id_rd_i == 5'(r)) begin
          load_cnt[r] <= 2'(LOAD_LAT);
          pend_load[r] <= 1'b1;
        end else if (load_cnt[r] != 2'd0) begin
          load_cnt[r] <= load_cnt[r] - 2'd1;
          pend_load[r] <= load_cnt[r] != 2'd1;
        end
        pend_long[r] <= (wr && is_long && sb.id_rd_i == 5'(r)) ||
                        (pend_long[r] && !(sb.long_done_i && sb.long_rd_i == 5'(r)));
      end
      long_cnt <= cnt_sum > 4'(MAX_LONG) ? 3'(MAX_LONG) : cnt_sum[2:0];
      err <= err | (sb.long_done_i & ~pend_long[sb.long_rd_i]) | (sb.issue_i & is_long & full);
    end
endmodule
